// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage core: EX forwarding, load-use stall, redirect flush,
// multi-cycle EX freeze and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned RADDR_W     = 5,
  parameter int unsigned MC_LAT      = 4,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [RADDR_W-1:0]     id_rs,
  input  logic [RADDR_W-1:0]     id_rt,
  input  logic                   id_uses_rs,
  input  logic                   id_uses_rt,
  input  logic [RADDR_W-1:0]     ex_rs,
  input  logic [RADDR_W-1:0]     ex_rt,
  input  logic [DATA_W-1:0]      ex_rs_data,
  input  logic [DATA_W-1:0]      ex_rt_data,
  input  logic                   ex_memread,
  input  logic [RADDR_W-1:0]     ex_wreg,
  input  logic                   ex_mc_start,
  input  logic                   redirect,
  input  logic                   mem_regwrite,
  input  logic                   wb_regwrite,
  input  logic [RADDR_W-1:0]     mem_wreg,
  input  logic [RADDR_W-1:0]     wb_wreg,
  input  logic [DATA_W-1:0]      mem_result,
  input  logic [DATA_W-1:0]      wb_data,
  output logic [1:0]             fwd_a_sel,
  output logic [1:0]             fwd_b_sel,
  output logic [DATA_W-1:0]      fwd_a_data,
  output logic [DATA_W-1:0]      fwd_b_data,
  output logic                   pc_we,
  output logic                   ifid_we,
  output logic                   idex_we,
  output logic                   ifid_flush,
  output logic                   idex_bubble,
  output logic                   exmem_bubble,
  output logic                   mc_busy,
  output logic                   mc_done,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int unsigned CntW = $clog2(MC_LAT);
  localparam logic [CntW-1:0] McInit = CntW'(MC_LAT - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [1:0] {
    StRun    = 2'b00,
    StMcWait = 2'b01
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        mc_cnt_q, mc_cnt_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic mem_hit_a, wb_hit_a, mem_hit_b, wb_hit_b;
  logic load_use;

  // Register 0 is hardwired, so a write to it must never be forwarded.
  assign mem_hit_a = mem_regwrite && (mem_wreg != '0) && (mem_wreg == ex_rs);
  assign wb_hit_a  = wb_regwrite  && (wb_wreg  != '0) && (wb_wreg  == ex_rs);
  assign mem_hit_b = mem_regwrite && (mem_wreg != '0) && (mem_wreg == ex_rt);
  assign wb_hit_b  = wb_regwrite  && (wb_wreg  != '0) && (wb_wreg  == ex_rt);

  always_comb begin
    fwd_a_sel  = 2'b00;
    fwd_a_data = ex_rs_data;
    if (mem_hit_a) begin
      fwd_a_sel  = 2'b10;
      fwd_a_data = mem_result;
    end else if (wb_hit_a) begin
      fwd_a_sel  = 2'b01;
      fwd_a_data = wb_data;
    end
  end

  always_comb begin
    fwd_b_sel  = 2'b00;
    fwd_b_data = ex_rt_data;
    if (mem_hit_b) begin
      fwd_b_sel  = 2'b10;
      fwd_b_data = mem_result;
    end else if (wb_hit_b) begin
      fwd_b_sel  = 2'b01;
      fwd_b_data = wb_data;
    end
  end

  assign load_use = ex_memread && (ex_wreg != '0) &&
                    ((id_uses_rs && (ex_wreg == id_rs)) || (id_uses_rt && (ex_wreg == id_rt)));

  always_comb begin
    state_d      = state_q;
    mc_cnt_d     = mc_cnt_q;
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    idex_we      = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    mc_busy      = 1'b0;
    mc_done      = 1'b0;
    unique case (state_q)
      StRun: begin
        if (redirect) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (ex_mc_start) begin
          pc_we        = 1'b0;
          ifid_we      = 1'b0;
          idex_we      = 1'b0;
          exmem_bubble = 1'b1;
          mc_busy      = 1'b1;
          state_d      = StMcWait;
          mc_cnt_d     = McInit;
        end else if (load_use) begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_bubble = 1'b1;
        end
      end
      StMcWait: begin
        mc_busy = 1'b1;
        if (mc_cnt_q > CntOne) begin
          pc_we        = 1'b0;
          ifid_we      = 1'b0;
          idex_we      = 1'b0;
          exmem_bubble = 1'b1;
          mc_cnt_d     = mc_cnt_q - CntOne;
        end else begin
          // Last occupancy cycle: the result leaves EX and the front end resumes.
          mc_done  = 1'b1;
          mc_cnt_d = '0;
          state_d  = StRun;
        end
      end
      default: begin
        state_d  = StRun;
        mc_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_we && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StRun;
      mc_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mc_cnt_q    <= mc_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
